prn_data_arb: RTL and testbench
===============================

# prn_data_arb

Parametrised, buffered replacement for the printhead data selector. Two sources, print data and command/special-pattern data, each write into a private FIFO. An arbiter gives print data priority but never splits a command packet. The selected word is registered toward the printhead shifter with a valid/ready handshake, and head-type-dependent bit masking is applied on the way out. It sits between the print-data formatter / command generator and the printhead serialiser.

## Interface
Parameters:
- `DW`, 4: data word width (≥2).
- `DEPTH`, 8: entries per source FIFO (power of 2, ≥2).
- `GAP_TYPE`, 8'h04: `PrintHead_Type` value that selects gap mode.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `PrintHead_Type` in 8: head type; sampled every cycle.
- `Prndata_en` in 1: print source eligible for arbitration.
- `CMD_en` in 1: command source eligible for arbitration.
- `prn_wr` in 1: push `Prn_Data` into the print FIFO.
- `Prn_Data` in DW: print data word.
- `cmd_wr` in 1: push `SPdata`/`cmd_last` into the command FIFO.
- `SPdata` in DW: command data word.
- `cmd_last` in 1: marks the final word of a command packet.
- `fifo_clr` in 1: synchronous flush of both FIFOs and the FSM.
- `prn_full`, `cmd_full` out 1: FIFO full (combinational from count).
- `ovf` out 1: sticky; set on a write to a full FIFO. Cleared by reset or `fifo_clr`.
- `F_data` out DW: registered output word.
- `F_valid` out 1: `F_data` holds a word.
- `F_src` out 1: 0 = print, 1 = command.
- `F_last` out 1: copy of `cmd_last` for command words; 0 for print words.
- `F_rdy` in 1: downstream accepts the word when `F_valid && F_rdy`.

## Operation
- **FIFOs:**
  - Each FIFO is DEPTH×DW; the command FIFO is DEPTH×(DW+1) to carry `last`.
  - Count is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - A write when full is dropped (FIFO contents unchanged) and sets `ovf`.
  - A simultaneous push and pop on a full FIFO is still a drop; full is evaluated before the pop.
  - A push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- **Load condition:** `load = !F_valid || F_rdy`.
- **FSM states:** IDLE, CMD_LOCK.
  - In IDLE, the grant goes to print if `Prndata_en` and the print FIFO is non-empty. Otherwise it goes to command if `CMD_en` and the command FIFO is non-empty. Otherwise there is no grant.
  - IDLE → CMD_LOCK when a command word with last=0 is popped.
  - In CMD_LOCK, the grant is command only, and only if `CMD_en` and the command FIFO is non-empty. Print is stalled even if pending.
  - CMD_LOCK → IDLE when a command word with last=1 is popped.
  - If `CMD_en` drops while in CMD_LOCK, the FSM holds CMD_LOCK and output stalls. The packet is never abandoned except by `fifo_clr` or reset.
- **Output register:**
  - On `load` with a grant: pop the granted FIFO; `F_data` = masked word, `F_valid`=1, and `F_src`/`F_last` are set accordingly.
  - On `load` without a grant: `F_valid`=0, `F_data`=0, `F_src`=0, `F_last`=0 (idle output is all-zero).
- **Masking:**
  - If `PrintHead_Type == GAP_TYPE`, bits at odd indices of the word are forced to 0 (bit i kept only for even i).
  - Otherwise the word passes unchanged.
  - The type is applied at load time; a type change does not alter an already-registered word.
- **`fifo_clr`:** empties both FIFOs, sets FSM=IDLE, clears `ovf`, and clears all output registers in the next cycle. It has priority over simultaneous writes, which are discarded.

## Timing
- **Reset values:** `F_data`=0, `F_valid`=0, `F_src`=0, `F_last`=0, `ovf`=0, both FIFOs empty, `prn_full`=`cmd_full`=0, FSM=IDLE.
- **Reset mid-operation:** everything returns to these values immediately. Buffered data is lost.
- **Latency:** a word written at edge N into an empty FIFO, with the output stage free, appears with `F_valid`=1 after edge N+1.
- **Throughput:** one word per cycle while `F_rdy`=1.
- **Hold under backpressure:** when `F_rdy`=0, `F_valid`/`F_data`/`F_src`/`F_last` hold and no pop occurs.
- **Arbitration timing:** the grant is combinational from the current state and flags. FSM and pointer updates occur at the same edge as the pop.

## Test plan
- **Basic print path:** reset, then write print words 0xA, 0x5 with `Prndata_en`=1, `F_rdy`=1, type 0x00. Required: `F_data` = 0xA then 0x5 on consecutive cycles starting one cycle after the first write, `F_src`=0, then `F_valid`=0 and `F_data`=0.
- **Packet lock:** load a 3-word command packet (0x1, 0x2, 0x3 with last on 0x3). Push print 0xF after the first command word is output. Required: output 0x1, 0x2, 0x3 (`F_last`=1 on 0x3), then 0xF.
- **Priority and gap mode:** with both FIFOs non-empty in IDLE, print is served first. With type 0x04, print 0xF outputs 0x5 and 0xA outputs 0x0.
- **Overflow:** write DEPTH+1 print words with `F_rdy`=0. Required: `prn_full`=1 after DEPTH writes, `ovf`=1 after the extra write. The first DEPTH words drain in order; the extra word is absent.
- **Backpressure:** hold `F_rdy`=0 for 5 cycles mid-stream. Required: the output is stable for those 5 cycles and no word is lost or duplicated.
- **Reset and clear mid-packet:** assert `rstn`=0 or `fifo_clr` mid-packet. Required: outputs are all zero, FSM=IDLE, and a new print word is served normally afterwards.

Source files
------------

// File: rtl/prn_data_arb.sv
// Printhead data selector: two buffered sources (print, command) with print priority,
// packet-atomic command arbitration and a registered, type-masked valid/ready output.
module prn_data_arb #(
  parameter int          DW       = 4,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  GAP_TYPE = 8'h04
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    PrintHead_Type,
  input  logic          Prndata_en,
  input  logic          CMD_en,
  input  logic          prn_wr,
  input  logic [DW-1:0] Prn_Data,
  input  logic          cmd_wr,
  input  logic [DW-1:0] SPdata,
  input  logic          cmd_last,
  input  logic          fifo_clr,
  output logic          prn_full,
  output logic          cmd_full,
  output logic          ovf,
  output logic [DW-1:0] F_data,
  output logic          F_valid,
  output logic          F_src,
  output logic          F_last,
  input  logic          F_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_CMD_LOCK
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] prn_mem [DEPTH];
  logic [DW:0]   cmd_mem [DEPTH];
  logic [AW-1:0] prn_wr_ptr_q, prn_rd_ptr_q, cmd_wr_ptr_q, cmd_rd_ptr_q;
  logic [CW-1:0] prn_cnt_q, cmd_cnt_q;

  logic          prn_empty, cmd_empty;
  logic          prn_push, prn_pop, cmd_push, cmd_pop;
  logic          load, grant_prn, grant_cmd;
  logic [DW-1:0] cmd_head_data;
  logic          cmd_head_last;

  logic [DW-1:0] f_data_q, f_data_d;
  logic          f_valid_q, f_valid_d;
  logic          f_src_q, f_src_d;
  logic          f_last_q, f_last_d;
  logic          ovf_q;

  function automatic logic [DW-1:0] gap_mask(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i += 2) r[i] = w[i];
    return r;
  endfunction

  assign prn_empty = (prn_cnt_q == '0);
  assign cmd_empty = (cmd_cnt_q == '0);
  assign prn_full  = (prn_cnt_q == CW'(DEPTH));
  assign cmd_full  = (cmd_cnt_q == CW'(DEPTH));

  // Full is judged on the pre-pop count, so a push into a full FIFO is dropped even if it pops.
  assign prn_push = prn_wr && !prn_full && !fifo_clr;
  assign cmd_push = cmd_wr && !cmd_full && !fifo_clr;

  assign load = !f_valid_q || F_rdy;

  assign cmd_head_data = cmd_mem[cmd_rd_ptr_q][DW-1:0];
  assign cmd_head_last = cmd_mem[cmd_rd_ptr_q][DW];

  always_comb begin
    grant_prn = 1'b0;
    grant_cmd = 1'b0;
    if (state_q == S_CMD_LOCK) begin
      grant_cmd = CMD_en && !cmd_empty;
    end else if (Prndata_en && !prn_empty) begin
      grant_prn = 1'b1;
    end else begin
      grant_cmd = CMD_en && !cmd_empty;
    end
  end

  assign prn_pop = load && grant_prn && !fifo_clr;
  assign cmd_pop = load && grant_cmd && !fifo_clr;

  always_comb begin
    state_d = state_q;
    if (cmd_pop) state_d = cmd_head_last ? S_IDLE : S_CMD_LOCK;
  end

  always_comb begin
    f_valid_d = 1'b0;
    f_data_d  = '0;
    f_src_d   = 1'b0;
    f_last_d  = 1'b0;
    if (grant_prn) begin
      f_valid_d = 1'b1;
      f_data_d  = prn_mem[prn_rd_ptr_q];
    end else if (grant_cmd) begin
      f_valid_d = 1'b1;
      f_data_d  = cmd_head_data;
      f_src_d   = 1'b1;
      f_last_d  = cmd_head_last;
    end
    if (PrintHead_Type == GAP_TYPE) f_data_d = gap_mask(f_data_d);
  end

  // NOTE: storage arrays carry no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (prn_push) prn_mem[prn_wr_ptr_q] <= Prn_Data;
    if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= {cmd_last, SPdata};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prn_wr_ptr_q <= '0;
      prn_rd_ptr_q <= '0;
      prn_cnt_q    <= '0;
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
    end else if (fifo_clr) begin
      prn_wr_ptr_q <= '0;
      prn_rd_ptr_q <= '0;
      prn_cnt_q    <= '0;
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
    end else begin
      if (prn_push) prn_wr_ptr_q <= prn_wr_ptr_q + AW'(1);
      if (prn_pop)  prn_rd_ptr_q <= prn_rd_ptr_q + AW'(1);
      if (prn_push && !prn_pop)      prn_cnt_q <= prn_cnt_q + CW'(1);
      else if (prn_pop && !prn_push) prn_cnt_q <= prn_cnt_q - CW'(1);
      if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + AW'(1);
      if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + AW'(1);
      if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + CW'(1);
      else if (cmd_pop && !cmd_push) cmd_cnt_q <= cmd_cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_src_q   <= 1'b0;
      f_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (fifo_clr) begin
      state_q   <= S_IDLE;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_src_q   <= 1'b0;
      f_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        f_valid_q <= f_valid_d;
        f_data_q  <= f_data_d;
        f_src_q   <= f_src_d;
        f_last_q  <= f_last_d;
      end
      if ((prn_wr && prn_full) || (cmd_wr && cmd_full)) ovf_q <= 1'b1;
    end
  end

  assign F_data  = f_data_q;
  assign F_valid = f_valid_q;
  assign F_src   = f_src_q;
  assign F_last  = f_last_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_prn_data_arb.sv
// Directed plus randomized bench for prn_data_arb, checked against a queue-based model
// of the two sources, the packet lock and the registered output.
module tb_prn_data_arb;

  localparam int         DW       = 4;
  localparam int         DEPTH    = 8;
  localparam logic [7:0] GAP_TYPE = 8'h04;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    PrintHead_Type;
  logic          Prndata_en, CMD_en, prn_wr, cmd_wr, cmd_last, fifo_clr, F_rdy;
  logic [DW-1:0] Prn_Data, SPdata;
  logic          prn_full, cmd_full, ovf, F_valid, F_src, F_last;
  logic [DW-1:0] F_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_prn_q[$];
  cmd_t          m_cmd_q[$];
  bit            m_locked, m_valid, m_src, m_last, m_ovf;
  logic [DW-1:0] m_data;

  prn_data_arb #(.DW(DW), .DEPTH(DEPTH), .GAP_TYPE(GAP_TYPE)) dut (
    .clk(clk), .rstn(rstn), .PrintHead_Type(PrintHead_Type),
    .Prndata_en(Prndata_en), .CMD_en(CMD_en),
    .prn_wr(prn_wr), .Prn_Data(Prn_Data),
    .cmd_wr(cmd_wr), .SPdata(SPdata), .cmd_last(cmd_last),
    .fifo_clr(fifo_clr), .prn_full(prn_full), .cmd_full(cmd_full), .ovf(ovf),
    .F_data(F_data), .F_valid(F_valid), .F_src(F_src), .F_last(F_last), .F_rdy(F_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] shape(input logic [DW-1:0] w, input logic [7:0] t);
    logic [DW-1:0] r;
    r = w;
    if (t == GAP_TYPE)
      for (int i = 0; i < DW; i++) if (i % 2 == 1) r[i] = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    m_prn_q.delete();
    m_cmd_q.delete();
    m_locked = 0; m_valid = 0; m_src = 0; m_last = 0; m_ovf = 0;
    m_data   = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit   load, prn_full_pre, cmd_full_pre;
    int   sel;
    cmd_t e;
    if (!rstn || fifo_clr) begin
      model_clear();
      return;
    end
    load         = !m_valid || F_rdy;
    prn_full_pre = (m_prn_q.size() == DEPTH);
    cmd_full_pre = (m_cmd_q.size() == DEPTH);
    sel = 0;
    if (m_locked) begin
      if (CMD_en && m_cmd_q.size() > 0) sel = 2;
    end else if (Prndata_en && m_prn_q.size() > 0) sel = 1;
    else if (CMD_en && m_cmd_q.size() > 0) sel = 2;
    if (load) begin
      m_valid = (sel != 0); m_src = 0; m_last = 0; m_data = '0;
      if (sel == 1) begin
        m_data = shape(m_prn_q.pop_front(), PrintHead_Type);
      end else if (sel == 2) begin
        e        = m_cmd_q.pop_front();
        m_data   = shape(e.data, PrintHead_Type);
        m_src    = 1;
        m_last   = e.last;
        m_locked = !e.last;
      end
    end
    if (prn_wr) begin
      if (prn_full_pre) m_ovf = 1; else m_prn_q.push_back(Prn_Data);
    end
    if (cmd_wr) begin
      if (cmd_full_pre) m_ovf = 1; else m_cmd_q.push_back({cmd_last, SPdata});
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".F_valid"},  F_valid,  m_valid);
    check({ph, ".F_data"},   F_data,   m_data);
    check({ph, ".F_src"},    F_src,    m_src);
    check({ph, ".F_last"},   F_last,   m_last);
    check({ph, ".ovf"},      ovf,      m_ovf);
    check({ph, ".prn_full"}, prn_full, m_prn_q.size() == DEPTH);
    check({ph, ".cmd_full"}, cmd_full, m_cmd_q.size() == DEPTH);
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  initial begin
    rstn = 1'b1; PrintHead_Type = 8'h00; Prndata_en = 0; CMD_en = 0;
    prn_wr = 0; cmd_wr = 0; cmd_last = 0; fifo_clr = 0; F_rdy = 1;
    Prn_Data = '0; SPdata = '0;
    model_clear();
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare_all("reset");
    rstn = 1'b1;
    step("idle");

    // Basic print path
    Prndata_en = 1; F_rdy = 1; PrintHead_Type = 8'h00;
    prn_wr = 1; Prn_Data = 4'hA; step("basic");
    Prn_Data = 4'h5;             step("basic");
    check("basic_first_data", F_data, 4'hA);
    check("basic_first_src", F_src, 1'b0);
    prn_wr = 0;                  step("basic");
    check("basic_second_data", F_data, 4'h5);
    step("basic");
    check("basic_idle_valid", F_valid, 1'b0);
    check("basic_idle_data", F_data, 4'h0);

    // Packet lock: print pushed mid-packet waits for the packet end
    CMD_en = 1;
    cmd_wr = 1; SPdata = 4'h1; cmd_last = 0; step("lock");
    SPdata = 4'h2;                         step("lock");
    check("lock_w1", F_data, 4'h1);
    SPdata = 4'h3; cmd_last = 1; prn_wr = 1; Prn_Data = 4'hF; step("lock");
    check("lock_w2", F_data, 4'h2);
    cmd_wr = 0; cmd_last = 0; prn_wr = 0;  step("lock");
    check("lock_w3", F_data, 4'h3);
    check("lock_w3_last", F_last, 1'b1);
    step("lock");
    check("lock_prn_after", F_data, 4'hF);
    check("lock_prn_src", F_src, 1'b0);
    step("lock");

    // Priority and gap mode
    Prndata_en = 0; CMD_en = 0; PrintHead_Type = GAP_TYPE;
    prn_wr = 1; Prn_Data = 4'hF;                          step("prio");
    Prn_Data = 4'hA; cmd_wr = 1; SPdata = 4'h7; cmd_last = 1; step("prio");
    prn_wr = 0; cmd_wr = 0; cmd_last = 0; Prndata_en = 1; CMD_en = 1;
    step("prio");
    check("gap_F", F_data, 4'h5);
    check("gap_F_src", F_src, 1'b0);
    step("prio");
    check("gap_A", F_data, 4'h0);
    check("gap_A_valid", F_valid, 1'b1);
    step("prio");
    check("gap_cmd", F_data, 4'h5);
    check("gap_cmd_src", F_src, 1'b1);
    step("prio");

    // Overflow
    PrintHead_Type = 8'h00; Prndata_en = 0; F_rdy = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      prn_wr = 1; Prn_Data = DW'(i); step("ovf_fill");
      if (i == DEPTH - 1) begin
        check("ovf_full_at_depth", prn_full, 1'b1);
        check("ovf_not_yet", ovf, 1'b0);
      end
      if (i == DEPTH) check("ovf_set", ovf, 1'b1);
    end
    prn_wr = 0; Prndata_en = 1; F_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step("ovf_drain");
      check("ovf_drain_order", F_data, DW'(i));
    end
    step("ovf_drain");
    check("ovf_extra_absent", F_valid, 1'b0);
    fifo_clr = 1; step("ovf_clr");
    check("ovf_cleared", ovf, 1'b0);
    fifo_clr = 0;

    // Backpressure: five stalled cycles mid-stream
    for (int i = 0; i < 12; i++) begin
      prn_wr = (i < 6); Prn_Data = DW'(i + 1);
      F_rdy  = !(i >= 3 && i < 8);
      step("bp");
      if (i >= 3 && i < 8) check("bp_hold", F_data, 4'h2);
      if (i == 8)  check("bp_resume", F_data, 4'h3);
      if (i == 11) check("bp_last", F_data, 4'h6);
    end
    prn_wr = 0; F_rdy = 1;
    step("bp");

    // fifo_clr mid-packet, with a simultaneous write that must be discarded
    CMD_en = 1;
    cmd_wr = 1; SPdata = 4'h1; cmd_last = 0; step("clr");
    SPdata = 4'h2;                         step("clr");
    SPdata = 4'h3; cmd_last = 1; fifo_clr = 1; step("clr");
    check("clr_valid", F_valid, 1'b0);
    check("clr_data", F_data, 4'h0);
    cmd_wr = 0; cmd_last = 0; fifo_clr = 0;
    prn_wr = 1; Prn_Data = 4'h9; step("clr");
    prn_wr = 0;                  step("clr");
    check("clr_then_prn", F_data, 4'h9);
    step("clr");

    // Asynchronous reset mid-packet
    cmd_wr = 1; SPdata = 4'h4; cmd_last = 0; step("rst");
    SPdata = 4'h8;                         step("rst");
    cmd_wr = 0;
    rstn = 0; model_clear();
    #1 compare_all("rst_async");
    check("rst_async_valid", F_valid, 1'b0);
    step("rst");
    rstn = 1;
    prn_wr = 1; Prn_Data = 4'h6; step("rst");
    prn_wr = 0;                  step("rst");
    check("rst_then_prn", F_data, 4'h6);
    check("rst_then_src", F_src, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      Prndata_en     = ($urandom_range(0, 3) != 0);
      CMD_en         = ($urandom_range(0, 4) != 0);
      prn_wr         = ($urandom_range(0, 1) == 1);
      Prn_Data       = DW'($urandom);
      cmd_wr         = ($urandom_range(0, 1) == 1);
      SPdata         = DW'($urandom);
      cmd_last       = ($urandom_range(0, 2) == 0);
      F_rdy          = ($urandom_range(0, 2) != 0);
      fifo_clr       = ($urandom_range(0, 59) == 0);
      PrintHead_Type = ($urandom_range(0, 1) == 1) ? GAP_TYPE : 8'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
